// File: rtl/mul_column_sequencer.sv
// Column-serial multiplier sequencer: pushes partial-product bits into the per-column shift registers and captures the compressor product.
// Latency: product valid W+LAT+1 cycles after the accept edge; in_ready only in IDLE, so one transaction at a time.
// Backpressure: product and out_valid held in DONE until out_ready; MUL_SEQ_CHECK_EN adds the err/err_prod reference check.
module mul_column_sequencer #(
    parameter int W   = 24,
    parameter int LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [2*W-2:0]   col_bit,
    input  logic [2*W-1:0]   prod_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_prod,
`ifdef MUL_SEQ_CHECK_EN
    output logic             err,
    output logic [2*W-1:0]   err_prod,
`endif
    output logic             busy
);

    localparam int KW = (W > 1) ? $clog2(W) : 1;
    localparam int LW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_r, b_r;
    logic [KW-1:0]   k_cnt;
    logic [LW-1:0]   w_cnt;
    logic            last_push;
    logic            wait_done;

    // Bit c is the push for column c at cycle k; leading pushes of short columns are zero
    // so that the final h_c pushes are exactly that column's partial products.
    function automatic logic [2*W-2:0] pp_column_bits(input logic [W-1:0] a,
                                                      input logic [W-1:0] b,
                                                      input int k);
        logic [2*W-2:0] bits;
        int h, jlo, t;
        bits = '0;
        for (int c = 0; c < 2*W-1; c++) begin
            h   = (c + 1 < 2*W - 1 - c) ? c + 1 : 2*W - 1 - c;
            jlo = (c - W + 1 > 0) ? c - W + 1 : 0;
            t   = k - (W - h);
            if (t >= 0)
                bits[c] = |((a >> (jlo + t)) & (b >> (c - jlo - t)) & W'(1));
        end
        return bits;
    endfunction

    assign last_push = (k_cnt == KW'(W - 1));
    assign wait_done = (w_cnt == LW'(LAT));

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)            state_nxt = LOAD;
            LOAD: if (last_push)           state_nxt = WAIT;
            WAIT: if (wait_done)           state_nxt = DONE;
            DONE: if (out_ready)           state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // col_bit leads the shift registers by one edge, so push k=0 is registered on the
    // accept edge itself. With LAT=0 the single WAIT cycle is the capture cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            k_cnt    <= '0;
            w_cnt    <= '0;
            col_bit  <= '0;
            out_prod <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        k_cnt   <= '0;
                        col_bit <= pp_column_bits(in_a, in_b, 0);
                    end
                end
                LOAD: begin
                    k_cnt   <= k_cnt + KW'(1);
                    w_cnt   <= '0;
                    col_bit <= last_push ? '0 : pp_column_bits(a_r, b_r, int'(k_cnt) + 1);
                end
                WAIT: begin
                    w_cnt <= w_cnt + LW'(1);
                    if (wait_done)
                        out_prod <= prod_in;
                end
                default: ;
            endcase
        end
    end

`ifdef MUL_SEQ_CHECK_EN
    logic [2*W-1:0] ref_prod;
    assign ref_prod = {{W{1'b0}}, a_r} * {{W{1'b0}}, b_r};

    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_prod <= '0;
        end else if (state == WAIT && wait_done && prod_in != ref_prod) begin
            err <= 1'b1;
            if (!err)
                err_prod <= ref_prod;
        end
    end
`endif

endmodule
